// File: rtl/inst_fetch_unit.sv
// Instruction fetch stage for the single-cycle RV32I core.
// Owns the PC, runs a req/ack handshake with a variable-latency instruction
// memory, and presents one registered instruction at a time to decode.
// Downstream can stall the held instruction or redirect the PC on a taken
// branch/jump; a misaligned redirect target parks the unit in a sticky
// error state that only reset clears.

module inst_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,

  // Instruction memory handshake
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,

  // Downstream control
  input  logic        stall,
  input  logic        redirect_en,
  input  logic [31:0] redirect_pc,

  // To decode / register_file
  output logic [31:0] inst_out,
  output logic        inst_valid,
  output logic [31:0] pc_out,
  output logic [31:0] pc_plus4,
  output logic        misalign_err
);

  // FETCH : request outstanding at r_pc, waiting for the ack.
  // FLUSH : a redirect abandoned a request that is still in flight; swallow
  //         its ack before issuing a new one.
  // VALID : holding a fetched instruction for decode.
  // ERR   : misaligned redirect seen; dead until reset.
  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_FLUSH = 2'd1,
    ST_VALID = 2'd2,
    ST_ERR   = 2'd3
  } state_t;

  state_t      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_inst;
  logic        r_valid;
  logic        r_err;

  state_t      w_state_nxt;
  logic [31:0] w_pc_nxt;
  logic [31:0] w_inst_nxt;
  logic        w_valid_nxt;
  logic        w_err_nxt;
  logic [31:0] w_pc_plus4;
  logic        w_redirect_aligned;

  // PC increment wraps naturally at 32 bits; no flag is raised on wrap.
  assign w_pc_plus4         = r_pc + 32'd4;
  assign w_redirect_aligned = (redirect_pc[1:0] == 2'b00);

  // State register; the reset is synchronous so it only acts on a rising edge.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_FETCH;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and next-datapath decode for every state.
  // NOTE: every signal driven here gets a default first, so no path through
  // the case leaves one unassigned and no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_inst_nxt  = r_inst;
    w_valid_nxt = r_valid;
    w_err_nxt   = r_err;

    unique case (r_state)
      ST_FETCH: begin
        if (redirect_en) begin
          // Redirect wins; a same-cycle ack is dropped on the floor.
          if (!w_redirect_aligned) begin
            w_err_nxt   = 1'b1;
            w_state_nxt = ST_ERR;
          end else begin
            w_pc_nxt    = redirect_pc;
            // Without an ack the old request is still in flight and its
            // response must be drained before re-requesting.
            w_state_nxt = imem_ack ? ST_FETCH : ST_FLUSH;
          end
        end else if (imem_ack) begin
          w_inst_nxt  = imem_rdata;
          w_valid_nxt = 1'b1;
          w_state_nxt = ST_VALID;
        end
      end

      ST_VALID: begin
        if (redirect_en) begin
          // Redirect has priority over stall; the held instruction is on the
          // wrong path and is retired as a bubble.
          w_valid_nxt = 1'b0;
          w_inst_nxt  = NOP_INST;
          if (!w_redirect_aligned) begin
            w_err_nxt   = 1'b1;
            w_state_nxt = ST_ERR;
          end else begin
            w_pc_nxt    = redirect_pc;
            w_state_nxt = ST_FETCH;
          end
        end else if (!stall) begin
          // Consumed: advance sequentially and fetch the next word.
          w_pc_nxt    = w_pc_plus4;
          w_valid_nxt = 1'b0;
          w_inst_nxt  = NOP_INST;
          w_state_nxt = ST_FETCH;
        end
      end

      ST_FLUSH: begin
        if (redirect_en) begin
          if (!w_redirect_aligned) begin
            w_err_nxt   = 1'b1;
            w_state_nxt = ST_ERR;
          end else begin
            // Newer target replaces the older one. If the stale ack lands in
            // this same cycle the drain is complete, otherwise keep waiting.
            w_pc_nxt    = redirect_pc;
            w_state_nxt = imem_ack ? ST_FETCH : ST_FLUSH;
          end
        end else if (imem_ack) begin
          // Stale response: discard imem_rdata and re-request at r_pc.
          w_state_nxt = ST_FETCH;
        end
      end

      ST_ERR: begin
        w_valid_nxt = 1'b0;
        w_inst_nxt  = NOP_INST;
      end

      default: begin
        w_state_nxt = ST_FETCH;
      end
    endcase
  end

  // Datapath registers: PC, held instruction, valid and sticky error.
  // NOTE: reset covers only these few control/datapath flops; there is no
  // storage array here, so everything gets a defined reset value.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pc    <= RESET_PC;
      r_inst  <= NOP_INST;
      r_valid <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_pc    <= w_pc_nxt;
      r_inst  <= w_inst_nxt;
      r_valid <= w_valid_nxt;
      r_err   <= w_err_nxt;
    end
  end

  // Output mapping: a request is only ever issued from FETCH.
  assign imem_req     = (r_state == ST_FETCH);
  assign imem_addr    = r_pc;
  assign pc_out       = r_pc;
  assign pc_plus4     = w_pc_plus4;
  assign inst_out     = r_inst;
  assign inst_valid   = r_valid;
  assign misalign_err = r_err;

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Self-checking bench for inst_fetch_unit: directed scenarios with literal
// expectations, then randomized traffic checked every cycle against a
// behavioural model of the fetch unit.

module tb_inst_fetch_unit;

  localparam logic [31:0] NOP   = 32'h0000_0013;
  localparam logic [31:0] INSTA = 32'h0030_8383;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic        stall = 1'b0;
  logic        redirect_en = 1'b0;
  logic [31:0] redirect_pc = 32'h0;

  logic        imem_req, inst_valid, misalign_err;
  logic [31:0] imem_addr, inst_out, pc_out, pc_plus4;

  logic        w_req, w_valid, w_err;
  logic [31:0] w_addr, w_inst, w_pc, w_pc4;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  inst_fetch_unit dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .stall(stall), .redirect_en(redirect_en), .redirect_pc(redirect_pc),
    .inst_out(inst_out), .inst_valid(inst_valid),
    .pc_out(pc_out), .pc_plus4(pc_plus4), .misalign_err(misalign_err)
  );

  // Second instance starting just below the 32-bit wrap point.
  inst_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clk(clk), .rst_n(rst_n),
    .imem_req(w_req), .imem_addr(w_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .stall(stall), .redirect_en(redirect_en), .redirect_pc(redirect_pc),
    .inst_out(w_inst), .inst_valid(w_valid),
    .pc_out(w_pc), .pc_plus4(w_pc4), .misalign_err(w_err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // The unit is seen as: is a request on the bus, is a stale response owed,
  // is an instruction being held, is the unit dead.
  bit          m_known = 0;
  bit          m_asking;     // request visible on the bus
  bit          m_owed;       // abandoned request whose ack must be swallowed
  bit          m_holding;    // instruction held for decode
  bit          m_dead;       // sticky misalignment
  logic [31:0] m_pc, m_inst;

  function automatic bit bad_target(input logic [31:0] t);
    return t[1:0] != 2'b00;
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      m_known = 1; m_asking = 1; m_owed = 0; m_holding = 0; m_dead = 0;
      m_pc = 32'h0; m_inst = NOP;
    end else if (m_known && !m_dead) begin
      if (redirect_en) begin
        // An in-flight request with no ack this cycle leaves a response owed.
        bit inflight;
        inflight = (m_asking || m_owed) && !imem_ack;
        m_holding = 0;
        m_inst    = NOP;
        if (bad_target(redirect_pc)) begin
          m_dead = 1; m_asking = 0; m_owed = 0;
        end else begin
          m_pc     = redirect_pc;
          m_owed   = inflight;
          m_asking = !inflight;
        end
      end else if (m_holding) begin
        if (!stall) begin
          m_pc = m_pc + 32'd4; m_holding = 0; m_inst = NOP; m_asking = 1;
        end
      end else if (imem_ack) begin
        if (m_owed) begin
          m_owed = 0; m_asking = 1;
        end else if (m_asking) begin
          m_inst = imem_rdata; m_holding = 1; m_asking = 0;
        end
      end
    end
  end

  // Single compare process: DUT against model on every falling edge.
  always @(negedge clk) begin
    if (m_known) begin
      check("req",      {31'b0, imem_req},     {31'b0, m_asking});
      check("addr",     imem_addr,             m_pc);
      check("pc",       pc_out,                m_pc);
      check("pc_plus4", pc_plus4,              m_pc + 32'd4);
      check("inst",     inst_out,              m_inst);
      check("valid",    {31'b0, inst_valid},   {31'b0, m_holding});
      check("err",      {31'b0, misalign_err}, {31'b0, m_dead});
    end
  end

  // Set inputs just after a falling edge, return at the next falling edge.
  task automatic step(input logic rn, input logic ack, input logic [31:0] rd,
                      input logic st, input logic re, input logic [31:0] rp);
    #1;
    rst_n = rn; imem_ack = ack; imem_rdata = rd;
    stall = st; redirect_en = re; redirect_pc = rp;
    @(negedge clk);
  endtask

  initial begin
    @(negedge clk);

    // 1: reset, then ack every cycle; pc sequence 0,0,4,4,8.
    step(0, 0, 0, 0, 0, 0);
    check("rst_pc", pc_out, 32'h0);
    check("rst_inst", inst_out, NOP);
    check("rst_valid", {31'b0, inst_valid}, 32'h0);
    check("rst_req", {31'b0, imem_req}, 32'h1);
    check("rst_err", {31'b0, misalign_err}, 32'h0);
    check("wrap_rst_pc", w_pc, 32'hFFFF_FFFC);
    check("wrap_pc4", w_pc4, 32'h0000_0000);
    step(1, 1, INSTA, 0, 0, 0);
    check("seq1_pc", pc_out, 32'h0);
    check("seq1_valid", {31'b0, inst_valid}, 32'h1);
    check("seq1_inst", inst_out, INSTA);
    step(1, 1, INSTA, 0, 0, 0);
    check("seq2_pc", pc_out, 32'h4);
    check("seq2_req", {31'b0, imem_req}, 32'h1);
    check("wrap_addr", w_addr, 32'h0000_0000);
    check("wrap_err", {31'b0, w_err}, 32'h0);
    step(1, 1, INSTA, 0, 0, 0);
    check("seq3_pc", pc_out, 32'h4);
    step(1, 1, INSTA, 0, 0, 0);
    check("seq4_pc", pc_out, 32'h8);

    // 2: ack delayed 3 cycles at pc 0 -> req high for 4 cycles.
    step(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      check("dly_req", {31'b0, imem_req}, 32'h1);
      step(1, 0, 0, 0, 0, 0);
      check("dly_valid", {31'b0, inst_valid}, 32'h0);
      check("dly_pc", pc_out, 32'h0);
    end
    check("dly_req4", {31'b0, imem_req}, 32'h1);
    step(1, 1, INSTA, 0, 0, 0);
    check("dly_valid_up", {31'b0, inst_valid}, 32'h1);

    // 3: stall 5 cycles while VALID.
    for (int i = 0; i < 5; i++) begin
      step(1, 0, 0, 1, 0, 0);
      check("stl_inst", inst_out, INSTA);
      check("stl_pc", pc_out, 32'h0);
      check("stl_valid", {31'b0, inst_valid}, 32'h1);
    end
    step(1, 0, 0, 0, 0, 0);
    check("stl_release_pc", pc_out, 32'h4);

    // 4: redirect in FETCH without ack -> FLUSH, late ack discarded.
    step(0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 1, 32'h100);
    check("fl_req", {31'b0, imem_req}, 32'h0);
    check("fl_pc", pc_out, 32'h100);
    step(1, 0, 0, 0, 0, 0);
    check("fl_req2", {31'b0, imem_req}, 32'h0);
    step(1, 1, 32'hDEAD_BEEF, 0, 0, 0);
    check("fl_valid", {31'b0, inst_valid}, 32'h0);
    check("fl_inst", inst_out, NOP);
    check("fl_addr", imem_addr, 32'h100);
    check("fl_req3", {31'b0, imem_req}, 32'h1);
    step(1, 1, INSTA, 0, 0, 0);
    check("fl_inst2", inst_out, INSTA);

    // 5: misaligned redirect -> sticky error, cleared by reset.
    step(1, 0, 0, 0, 1, 32'h102);
    check("mis_err", {31'b0, misalign_err}, 32'h1);
    check("mis_pc", pc_out, 32'h100);
    for (int i = 0; i < 3; i++) begin
      step(1, 1, INSTA, 0, 0, 0);
      check("mis_req", {31'b0, imem_req}, 32'h0);
      check("mis_valid", {31'b0, inst_valid}, 32'h0);
    end
    step(0, 0, 0, 0, 1, 32'h200);
    check("mis_clr", {31'b0, misalign_err}, 32'h0);
    check("mis_restart", imem_addr, 32'h0);

    // Randomized traffic; the compare process checks every cycle.
    for (int i = 0; i < 3000; i++) begin
      logic        rn, ack, st, re;
      logic [31:0] rp;
      rn  = ($urandom_range(0, 63) != 0);
      ack = ($urandom_range(0, 9) < 4);
      st  = ($urandom_range(0, 2) == 0);
      re  = ($urandom_range(0, 7) == 0);
      rp  = {$urandom_range(0, 32'hFFFF), 16'h0} | {$urandom_range(0, 255), 2'b00};
      if ($urandom_range(0, 15) == 0) rp[1:0] = 2'($urandom_range(1, 3));
      step(rn, ack, $urandom, st, re, rp);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
